// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial bit-sequence detector with registered match pulse
// Define SEQ_DET_CNT_EN to build the saturating match counter; otherwise match_cnt is tied to 0.
module seq_detector_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         x,
    input  logic                         x_vld,
    output logic                         y,
    output logic [$clog2(PAT_LEN+1)-1:0] fill,
    output logic [CNT_W-1:0]             match_cnt
);
    localparam int                FILL_W = $clog2(PAT_LEN+1);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] hist_q;
    logic [PAT_LEN-1:0] hist_d;
    logic [FILL_W-1:0]  fill_q;
    logic [FILL_W-1:0]  fill_d;
    logic               y_q;
    logic               y_d;
    logic [PAT_LEN-1:0] hist_shift;
    logic [FILL_W-1:0]  fill_inc;
    logic               hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
            y_q    <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            y_q    <= y_d;
        end
    end

    // A match needs a full history so an all-zero pattern cannot fire out of reset.
    always_comb begin
        hist_shift = {hist_q[PAT_LEN-2:0], x};
        fill_inc   = (fill_q == FULL) ? fill_q : fill_q + FILL_W'(1);
        hit        = (fill_inc == FULL) && (hist_shift == PATTERN);
        hist_d     = hist_q;
        fill_d     = fill_q;
        y_d        = 1'b0;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (x_vld) begin
            hist_d = hist_shift;
            fill_d = (hit && !OVERLAP) ? '0 : fill_inc;
            y_d    = hit;
        end
    end

    always_comb begin
        y    = y_q;
        fill = fill_q;
    end

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (y_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule
